// File: rtl/aes_decrypt_core.sv
// AES-128 decryption core (one inverse round per clock) together with the round primitives it uses.
// Optional feature: define AES_DEC_FLUSH_EN to add a flush input that abandons the block in flight.

package aes_pkg;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse computed as x^254, which also maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inverse);
        logic [7:0] y;
        if (inverse) begin
            y = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
            return gf_inv(y);
        end
        y = gf_inv(x);
        return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
    endfunction

endpackage

module shift_rows #(
    parameter int INVERSE = 0
) (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int SRC = (INVERSE != 0) ? (c + 4 - r) % 4 : (c + r) % 4;
            assign dout[8*(4*c+r) +: 8] = din[8*(4*SRC+r) +: 8];
        end
    end
endmodule

module sub_bytes #(
    parameter int INVERSE = 0
) (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = aes_pkg::sbox(din[8*i +: 8], INVERSE != 0);
    end
endmodule

module mix_columns #(
    parameter int INVERSE = 0
) (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    localparam logic [7:0] K0 = (INVERSE != 0) ? 8'h0e : 8'h02;
    localparam logic [7:0] K1 = (INVERSE != 0) ? 8'h0b : 8'h03;
    localparam logic [7:0] K2 = (INVERSE != 0) ? 8'h0d : 8'h01;
    localparam logic [7:0] K3 = (INVERSE != 0) ? 8'h09 : 8'h01;

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[8*(4*c+r) +: 8] =
                aes_pkg::gf_mul(K0, din[8*(4*c+r) +: 8]) ^
                aes_pkg::gf_mul(K1, din[8*(4*c+(r+1)%4) +: 8]) ^
                aes_pkg::gf_mul(K2, din[8*(4*c+(r+2)%4) +: 8]) ^
                aes_pkg::gf_mul(K3, din[8*(4*c+(r+3)%4) +: 8]);
        end
    end
endmodule

module aes_decrypt_core #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ct_valid,
    output logic         ct_ready,
    input  logic [127:0] ciphertext,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         pt_valid,
    input  logic         pt_ready,
`ifdef AES_DEC_FLUSH_EN
    input  logic         flush,
`endif
    output logic [127:0] plaintext
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         ct_ready_q, ct_ready_d;
    logic         pt_valid_q, pt_valid_d;

    logic [127:0] inv_sr, inv_sb, add_rk, inv_mc;

    shift_rows  #(.INVERSE(1)) u_inv_shift_rows (.din(state_q), .dout(inv_sr));
    sub_bytes   #(.INVERSE(1)) u_inv_sub_bytes  (.din(inv_sr),  .dout(inv_sb));
    assign add_rk = inv_sb ^ rk;
    mix_columns #(.INVERSE(1)) u_inv_mix_columns(.din(add_rk),  .dout(inv_mc));

    // Key index decodes registered state only, so the key store never sees ct_valid/pt_ready.
    assign rk_idx    = (fsm_q == IDLE) ? 4'(NUM_ROUNDS) : round_q;
    assign ct_ready  = ct_ready_q;
    assign pt_valid  = pt_valid_q;
    assign plaintext = state_q;

    always_comb begin
        // NOTE: every _d is defaulted to its _q first so no path through the case infers a latch.
        fsm_d      = fsm_q;
        state_d    = state_q;
        round_d    = round_q;
        ct_ready_d = ct_ready_q;
        pt_valid_d = pt_valid_q;
        unique case (fsm_q)
            IDLE: if (ct_valid && ct_ready_q) begin
                state_d    = ciphertext ^ rk;
                round_d    = 4'(NUM_ROUNDS - 1);
                fsm_d      = ROUND;
                ct_ready_d = 1'b0;
            end
            ROUND: if (round_q != 4'd0) begin
                state_d = inv_mc;
                round_d = round_q - 4'd1;
            end else begin
                state_d    = add_rk;
                fsm_d      = DONE;
                pt_valid_d = 1'b1;
            end
            DONE: if (pt_ready) begin
                fsm_d      = IDLE;
                pt_valid_d = 1'b0;
                ct_ready_d = 1'b1;
            end
            default: fsm_d = IDLE;
        endcase
`ifdef AES_DEC_FLUSH_EN
        // Flush overrides any handshake and deliberately leaves the data register untouched.
        if (flush && fsm_q != IDLE) begin
            fsm_d      = IDLE;
            state_d    = state_q;
            round_d    = round_q;
            pt_valid_d = 1'b0;
            ct_ready_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            // NOTE: the data register is reset as well because plaintext must read zero out of reset.
            state_q    <= '0;
            round_q    <= '0;
            ct_ready_q <= 1'b1;
            pt_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            round_q    <= round_d;
            ct_ready_q <= ct_ready_d;
            pt_valid_q <= pt_valid_d;
        end
    end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core: FIPS-197 C.1 vector plus random blocks built by a forward AES model.
// Expected plaintexts go into a scoreboard queue at acceptance and are compared at the plaintext handshake.

module tb_aes_decrypt_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, ct_valid, ct_ready, pt_valid, pt_ready;
    logic [127:0] ciphertext, rk, plaintext;
    logic [3:0]   rk_idx;
`ifdef AES_DEC_FLUSH_EN
    logic         flush;
`endif

    logic [127:0] rk_tab [0:10];
    logic [127:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    assign rk = (rk_idx <= 4'd10) ? rk_tab[rk_idx] : '0;

    aes_decrypt_core #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .rst_n(rst_n), .ct_valid(ct_valid), .ct_ready(ct_ready),
        .ciphertext(ciphertext), .rk_idx(rk_idx), .rk(rk), .pt_valid(pt_valid),
        .pt_ready(pt_ready),
`ifdef AES_DEC_FLUSH_EN
        .flush(flush),
`endif
        .plaintext(plaintext));

    // ---------------- forward AES reference model ----------------
    function automatic logic [7:0] fsb(input logic [7:0] x);
        return SBOX[8*int'(x) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k, input bit last);
        logic [127:0] t, u;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) t[8*i +: 8] = fsb(s[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                u[8*(4*c+r) +: 8] = t[8*(4*((c+r)%4)+r) +: 8];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = u[32*c +: 8]; a1 = u[32*c+8 +: 8]; a2 = u[32*c+16 +: 8]; a3 = u[32*c+24 +: 8];
                u[32*c    +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                u[32*c+8  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                u[32*c+16 +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                u[32*c+24 +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return u ^ k;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_tab[0];
        for (int r = 1; r <= 10; r++) s = enc_round(s, rk_tab[r], r == 10);
        return s;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {fsb(t[31:24]), fsb(t[23:16]), fsb(t[15:8]), fsb(t[7:0]) ^ rcon};
                rcon = xt(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk_tab[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- driver / monitor helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] ct, input logic [127:0] exp);
        bit ok;
        ok = 1'b0;
        ct_valid = 1'b1;
        ciphertext = ct;
        for (int i = 0; i < 50; i++) begin
            if (ct_ready) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL send_timeout: ct_ready=%0b after 50 cycles, required 1", ct_ready);
            ct_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        tick();
        ct_valid = 1'b0;
    endtask

    task automatic wait_pt();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pt_valid) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL pt_valid_timeout: pt_valid=%0b after 60 cycles, required 1", pt_valid);
        end
    endtask

    task automatic recv(input int delay);
        logic [127:0] exp;
        pt_ready = 1'b0;
        wait_pt();
        repeat (delay) tick();
        pt_ready = 1'b1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: got plaintext %h with nothing expected", plaintext);
        end else begin
            exp = exp_q.pop_front();
            if (!pt_valid || plaintext !== exp) begin
                n_errors++;
                $display("FAIL plaintext: valid=%0b got %h, required %h", pt_valid, plaintext, exp);
            end
        end
        tick();
        pt_ready = 1'b0;
        n_checks++;
        if (pt_valid !== 1'b0 || ct_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL after_handshake: pt_valid=%0b ct_ready=%0b, required 0/1", pt_valid, ct_ready);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input bit expect_zero_pt);
        n_checks++;
        if (ct_ready !== 1'b1 || pt_valid !== 1'b0 || rk_idx !== 4'd10 ||
            (expect_zero_pt && plaintext !== '0)) begin
            n_errors++;
            $display("FAIL %s: ct_ready=%0b pt_valid=%0b rk_idx=%0d plaintext=%h, required 1/0/10%s",
                     tag, ct_ready, pt_valid, rk_idx, plaintext, expect_zero_pt ? "/0" : "");
        end
    endtask

    task automatic wait_round(input logic [3:0] r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rk_idx == r) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL wait_round: rk_idx=%0d, required %0d within 20 cycles", rk_idx, r);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        check_idle_outputs("reset_state", 1'b1);
        tick();
        check_idle_outputs("reset_state_hold", 1'b1);
    endtask

    task automatic test_fips_c1();
        pt_ready = 1'b0;
        ct_valid = 1'b1;
        ciphertext = C1_CT;
        check_idle_outputs("accept_cycle", 1'b0);
        exp_q.push_back(C1_PT);
        tick();
        ct_valid = 1'b0;
        // Accepting edge is edge 1; rounds 9..0 occupy edges 1..10; pt_valid rises at edge 11.
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (rk_idx !== 4'(9 - k) || pt_valid !== 1'b0 || ct_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL rk_trace[%0d]: rk_idx=%0d pt_valid=%0b ct_ready=%0b, required %0d/0/0",
                         k, rk_idx, pt_valid, ct_ready, 9 - k);
            end
            tick();
        end
        n_checks++;
        if (pt_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL latency: pt_valid=%0b at edge 11, required 1", pt_valid);
        end
        recv(0);
    endtask

    task automatic test_hold();
        logic [127:0] pt, exp;
        pt = rand128();
        send(encrypt(pt), pt);
        pt_ready = 1'b0;
        wait_pt();
        exp = (exp_q.size() != 0) ? exp_q[0] : '0;
        ct_valid = 1'b1;
        ciphertext = encrypt(~pt);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (pt_valid !== 1'b1 || plaintext !== exp || ct_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL hold[%0d]: pt_valid=%0b ct_ready=%0b plaintext=%h, required 1/0/%h",
                         i, pt_valid, ct_ready, plaintext, exp);
            end
            tick();
        end
        ct_valid = 1'b0;
        recv(0);
    endtask

    task automatic test_reset_mid();
        bit saw;
        send(C1_CT, C1_PT);
        wait_round(4'd4);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("reset_mid_round", 1'b1);
        rst_n = 1'b1;
        exp_q.delete();
        saw = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (pt_valid) saw = 1'b1;
            tick();
        end
        n_checks++;
        if (saw) begin
            n_errors++;
            $display("FAIL reset_abandon: pt_valid pulsed after reset, required none");
        end
        send(C1_CT, C1_PT);
        recv(1);
    endtask

    task automatic test_random();
        logic [127:0] pt;
        for (int i = 0; i < 6; i++) begin
            pt = rand128();
            send(encrypt(pt), pt);
            recv(int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pt_a, pt_b, ct_b, exp;
        int n_acc, n_out, hs_cyc, acc_b_cyc;
        pt_a = rand128();
        pt_b = rand128();
        ct_b = encrypt(pt_b);
        n_acc = 0; n_out = 0; hs_cyc = -100; acc_b_cyc = -1;
        ct_valid = 1'b1;
        pt_ready = 1'b1;
        ciphertext = encrypt(pt_a);
        for (int cyc = 0; cyc < 40 && n_out < 2; cyc++) begin
            if (ct_valid && ct_ready) begin
                exp_q.push_back(n_acc == 0 ? pt_a : pt_b);
                if (n_acc == 1) acc_b_cyc = cyc;
                n_acc++;
            end
            if (pt_valid) begin
                n_checks++;
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                if (plaintext !== exp) begin
                    n_errors++;
                    $display("FAIL b2b_plaintext[%0d]: got %h, required %h", n_out, plaintext, exp);
                end
                if (n_out == 0) hs_cyc = cyc;
                n_out++;
            end
            tick();
            if (n_acc == 1) ciphertext = ct_b;
            if (n_acc == 2) ct_valid = 1'b0;
        end
        ct_valid = 1'b0;
        pt_ready = 1'b0;
        n_checks++;
        if (n_out != 2 || acc_b_cyc != hs_cyc + 1) begin
            n_errors++;
            $display("FAIL b2b_timing: outputs=%0d second_accept=%0d handshake=%0d, required 2 and accept=handshake+1",
                     n_out, acc_b_cyc, hs_cyc);
        end
    endtask

`ifdef AES_DEC_FLUSH_EN
    task automatic test_flush();
        logic [127:0] pt, pt_c;
        pt   = rand128();
        pt_c = rand128();
        send(encrypt(pt), pt);
        wait_round(4'd6);
        flush = 1'b1;
        ct_valid = 1'b1;
        ciphertext = encrypt(pt_c);
        n_checks++;
        if (ct_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_ct_ready: ct_ready=%0b during flush cycle, required 0", ct_ready);
        end
        tick();
        flush = 1'b0;
        exp_q.delete();
        check_idle_outputs("flush_idle", 1'b0);
        exp_q.push_back(pt_c);
        tick();
        ct_valid = 1'b0;
        n_checks++;
        if (ct_ready !== 1'b0 || rk_idx !== 4'd9) begin
            n_errors++;
            $display("FAIL flush_reaccept: ct_ready=%0b rk_idx=%0d, required 0/9", ct_ready, rk_idx);
        end
        recv(0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        ct_valid = 1'b0;
        pt_ready = 1'b0;
        ciphertext = '0;
`ifdef AES_DEC_FLUSH_EN
        flush = 1'b0;
`endif
        expand_key(C1_KEY);
        test_reset();
        test_fips_c1();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
`ifdef AES_DEC_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
